layer_storage: RTL and testbench

Parameter and activation storage for one DNN layer. It holds two independent memories:
- an activation/output memory (`act_*` ports), indexed by entry, row and column;
- a weight memory with a per-row bias array (`wt_*` ports), indexed by output channel, input channel, kernel row and kernel column.

Both memories have synchronous write and combinational read. A layer controller can therefore issue a read address on one clock edge and consume the data on the next edge. Data words are opaque 64-bit (IEEE-754 double) values.

---
 rtl/layer_storage_if.sv | 55 +++++
 rtl/layer_storage.sv | 123 ++++++++++++
 tb/tb_layer_storage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_storage_if.sv
// Write/read bus of the layer parameter and activation storage.
interface layer_storage_if #(
    parameter int unsigned DATA_SIZE = 64
);
    // Activation memory
    logic                 act_write;
    logic [DATA_SIZE-1:0] act_in_data;
    logic [15:0]          act_index_entry;
    logic [15:0]          act_index_y;
    logic [15:0]          act_index_x;
    logic [15:0]          act_read_index_entry;
    logic [15:0]          act_read_index_y;
    logic [15:0]          act_read_index_x;
    logic [DATA_SIZE-1:0] act_out_data;

    // Weight memory and bias array
    logic                 wt_weight_write;
    logic                 wt_bias_write;
    logic [DATA_SIZE-1:0] wt_in_data;
    logic [15:0]          wt_index_in;
    logic [15:0]          wt_index_out;
    logic [15:0]          wt_index_k_y;
    logic [15:0]          wt_index_k_x;
    logic [15:0]          wt_read_index_in;
    logic [15:0]          wt_read_index_out;
    logic [15:0]          wt_read_index_y;
    logic [15:0]          wt_read_index_x;
    logic [15:0]          wt_read_index_bias;
    logic [DATA_SIZE-1:0] wt_out_data_weight;
    logic [DATA_SIZE-1:0] wt_out_data_bias;

    // Layer controller side
    modport master (
        output act_write, act_in_data, act_index_entry, act_index_y, act_index_x,
        output act_read_index_entry, act_read_index_y, act_read_index_x,
        input  act_out_data,
        output wt_weight_write, wt_bias_write, wt_in_data,
        output wt_index_in, wt_index_out, wt_index_k_y, wt_index_k_x,
        output wt_read_index_in, wt_read_index_out, wt_read_index_y, wt_read_index_x,
        output wt_read_index_bias,
        input  wt_out_data_weight, wt_out_data_bias
    );

    // Storage side
    modport slave (
        input  act_write, act_in_data, act_index_entry, act_index_y, act_index_x,
        input  act_read_index_entry, act_read_index_y, act_read_index_x,
        output act_out_data,
        input  wt_weight_write, wt_bias_write, wt_in_data,
        input  wt_index_in, wt_index_out, wt_index_k_y, wt_index_k_x,
        input  wt_read_index_in, wt_read_index_out, wt_read_index_y, wt_read_index_x,
        input  wt_read_index_bias,
        output wt_out_data_weight, wt_out_data_bias
    );
endinterface

// File: rtl/layer_storage.sv
// Activation, weight and bias storage for one DNN layer.
// Synchronous writes, combinational reads, out-of-range accesses are
// dropped on write and read back as zero.
module layer_storage #(
    parameter int unsigned DATA_SIZE      = 64,
    parameter int unsigned ACT_DIM        = 800,
    parameter int unsigned ACT_ENTRIES    = 1,
    parameter int unsigned WT_NUM_INPUTS  = 1,
    parameter int unsigned WT_NUM_OUTPUTS = 1,
    parameter int unsigned WT_DIM         = 800,
    parameter int unsigned DEBUG          = 0,
    parameter string       NAME           = "LAYER_STORAGE"
) (
    input  logic            clk,
    input  logic            rst_n,
    layer_storage_if.slave  bus
);

    localparam int unsigned ACT_E      = (ACT_ENTRIES > 0) ? ACT_ENTRIES : 1;
    localparam int unsigned ACT_DEPTH  = ACT_E * ACT_DIM * ACT_DIM;
    localparam int unsigned WT_DEPTH   = WT_NUM_OUTPUTS * WT_NUM_INPUTS * WT_DIM * WT_DIM;
    localparam int unsigned BIAS_DEPTH = WT_NUM_OUTPUTS * WT_DIM;
    localparam int unsigned ACT_AW     = (ACT_DEPTH  > 1) ? $clog2(ACT_DEPTH)  : 1;
    localparam int unsigned WT_AW      = (WT_DEPTH   > 1) ? $clog2(WT_DEPTH)   : 1;
    localparam int unsigned BIAS_AW    = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1;

    // Write tracing parameters carry no hardware.
    logic unused_debug;
    assign unused_debug = (DEBUG != 0) || (NAME == "");

    // One level of row-major flattening: hi * ext + lo.
    function automatic logic [63:0] flat(input logic [63:0] hi, input logic [15:0] lo,
                                         input int unsigned ext);
        return hi * 64'(ext) + 64'(lo);
    endfunction

    function automatic logic in_range(input logic [15:0] idx, input int unsigned ext);
        return 32'(idx) < ext;
    endfunction

    logic [DATA_SIZE-1:0] act_mem  [ACT_DEPTH];
    logic [DATA_SIZE-1:0] wt_mem   [WT_DEPTH];
    logic [DATA_SIZE-1:0] bias_mem [BIAS_DEPTH];

    logic               act_wr_ok,   act_rd_ok;
    logic               wt_wr_ok,    wt_rd_ok;
    logic               bias_wr_ok,  bias_rd_ok;
    logic [ACT_AW-1:0]  act_wr_addr, act_rd_addr;
    logic [WT_AW-1:0]   wt_wr_addr,  wt_rd_addr;
    logic [BIAS_AW-1:0] bias_wr_addr, bias_rd_addr;

    // Address flattening and bounds checks for every port.
    always_comb begin
        act_wr_ok = bus.act_write
                  && in_range(bus.act_index_entry, ACT_E)
                  && in_range(bus.act_index_y, ACT_DIM)
                  && in_range(bus.act_index_x, ACT_DIM);
        act_rd_ok = in_range(bus.act_read_index_entry, ACT_E)
                  && in_range(bus.act_read_index_y, ACT_DIM)
                  && in_range(bus.act_read_index_x, ACT_DIM);
        act_wr_addr = ACT_AW'(flat(flat(64'(bus.act_index_entry), bus.act_index_y, ACT_DIM),
                                   bus.act_index_x, ACT_DIM));
        act_rd_addr = ACT_AW'(flat(flat(64'(bus.act_read_index_entry), bus.act_read_index_y,
                                        ACT_DIM), bus.act_read_index_x, ACT_DIM));

        wt_wr_ok = bus.wt_weight_write
                 && in_range(bus.wt_index_out, WT_NUM_OUTPUTS)
                 && in_range(bus.wt_index_in, WT_NUM_INPUTS)
                 && in_range(bus.wt_index_k_y, WT_DIM)
                 && in_range(bus.wt_index_k_x, WT_DIM);
        wt_rd_ok = in_range(bus.wt_read_index_out, WT_NUM_OUTPUTS)
                 && in_range(bus.wt_read_index_in, WT_NUM_INPUTS)
                 && in_range(bus.wt_read_index_y, WT_DIM)
                 && in_range(bus.wt_read_index_x, WT_DIM);
        wt_wr_addr = WT_AW'(flat(flat(flat(64'(bus.wt_index_out), bus.wt_index_in,
                                           WT_NUM_INPUTS), bus.wt_index_k_y, WT_DIM),
                                 bus.wt_index_k_x, WT_DIM));
        wt_rd_addr = WT_AW'(flat(flat(flat(64'(bus.wt_read_index_out), bus.wt_read_index_in,
                                           WT_NUM_INPUTS), bus.wt_read_index_y, WT_DIM),
                                 bus.wt_read_index_x, WT_DIM));

        bias_wr_ok = bus.wt_bias_write
                   && in_range(bus.wt_index_out, WT_NUM_OUTPUTS)
                   && in_range(bus.wt_index_k_y, WT_DIM);
        bias_rd_ok = in_range(bus.wt_read_index_out, WT_NUM_OUTPUTS)
                   && in_range(bus.wt_read_index_bias, WT_DIM);
        bias_wr_addr = BIAS_AW'(flat(64'(bus.wt_index_out), bus.wt_index_k_y, WT_DIM));
        bias_rd_addr = BIAS_AW'(flat(64'(bus.wt_read_index_out), bus.wt_read_index_bias, WT_DIM));
    end

    // Activation array: cleared while in reset, one write per cycle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ACT_DEPTH; i++) act_mem[ACT_AW'(i)] <= '0;
        end else if (act_wr_ok) begin
            act_mem[act_wr_addr] <= bus.act_in_data;
        end
    end

    // Weight array: cleared while in reset, one write per cycle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WT_DEPTH; i++) wt_mem[WT_AW'(i)] <= '0;
        end else if (wt_wr_ok) begin
            wt_mem[wt_wr_addr] <= bus.wt_in_data;
        end
    end

    // Bias array: shares write data with the weights, independent enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BIAS_DEPTH; i++) bias_mem[BIAS_AW'(i)] <= '0;
        end else if (bias_wr_ok) begin
            bias_mem[bias_wr_addr] <= bus.wt_in_data;
        end
    end

    // Combinational read ports; invalid addresses read as zero.
    assign bus.act_out_data       = act_rd_ok  ? act_mem[act_rd_addr]   : '0;
    assign bus.wt_out_data_weight = wt_rd_ok   ? wt_mem[wt_rd_addr]     : '0;
    assign bus.wt_out_data_bias   = bias_rd_ok ? bias_mem[bias_rd_addr] : '0;

endmodule

// File: tb/tb_layer_storage.sv
// Directed self-checking bench for layer_storage with small extents.
module tb_layer_storage;

    localparam int D  = 4;
    localparam int E  = 2;
    localparam int NI = 2;
    localparam int NO = 2;

    localparam logic [63:0] F1_5  = 64'h3FF8000000000000;
    localparam logic [63:0] F2_0  = 64'h4000000000000000;
    localparam logic [63:0] F0_25 = 64'h3FD0000000000000;
    localparam logic [63:0] FM1_0 = 64'hBFF0000000000000;
    localparam logic [63:0] F3_0  = 64'h4008000000000000;
    localparam logic [63:0] F5_0  = 64'h4014000000000000;
    localparam logic [63:0] F7_0  = 64'h401C000000000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    layer_storage_if #(.DATA_SIZE(64)) bus ();

    layer_storage #(
        .DATA_SIZE(64), .ACT_DIM(D), .ACT_ENTRIES(E),
        .WT_NUM_INPUTS(NI), .WT_NUM_OUTPUTS(NO), .WT_DIM(D),
        .DEBUG(0), .NAME("LS_TB")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model: plain multi-dimensional arrays indexed by the logical coordinates.
    logic [63:0] act_m  [E][D][D];
    logic [63:0] wt_m   [NO][NI][D][D];
    logic [63:0] bias_m [NO][D];

    function automatic void model_clear();
        for (int e = 0; e < E; e++) for (int y = 0; y < D; y++) for (int x = 0; x < D; x++)
            act_m[e][y][x] = '0;
        for (int o = 0; o < NO; o++) for (int i = 0; i < NI; i++)
            for (int y = 0; y < D; y++) for (int x = 0; x < D; x++) wt_m[o][i][y][x] = '0;
        for (int o = 0; o < NO; o++) for (int y = 0; y < D; y++) bias_m[o][y] = '0;
    endfunction

    function automatic logic [63:0] exp_act(int e, int y, int x);
        if (e < E && y < D && x < D) return act_m[e][y][x];
        return '0;
    endfunction

    function automatic logic [63:0] exp_wt(int o, int i, int y, int x);
        if (o < NO && i < NI && y < D && x < D) return wt_m[o][i][y][x];
        return '0;
    endfunction

    function automatic logic [63:0] exp_bias(int o, int b);
        if (o < NO && b < D) return bias_m[o][b];
        return '0;
    endfunction

    always @(negedge rst_n) model_clear();

    // Model write side: a write lands at the edge only when out of reset and in range.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.act_write && int'(bus.act_index_entry) < E
                && int'(bus.act_index_y) < D && int'(bus.act_index_x) < D)
                act_m[bus.act_index_entry][bus.act_index_y][bus.act_index_x] <= bus.act_in_data;
            if (bus.wt_weight_write && int'(bus.wt_index_out) < NO && int'(bus.wt_index_in) < NI
                && int'(bus.wt_index_k_y) < D && int'(bus.wt_index_k_x) < D)
                wt_m[bus.wt_index_out][bus.wt_index_in][bus.wt_index_k_y][bus.wt_index_k_x]
                    <= bus.wt_in_data;
            if (bus.wt_bias_write && int'(bus.wt_index_out) < NO && int'(bus.wt_index_k_y) < D)
                bias_m[bus.wt_index_out][bus.wt_index_k_y] <= bus.wt_in_data;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle, all three read ports against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("act_port", bus.act_out_data,
                  exp_act(int'(bus.act_read_index_entry), int'(bus.act_read_index_y),
                          int'(bus.act_read_index_x)));
            check("wt_port", bus.wt_out_data_weight,
                  exp_wt(int'(bus.wt_read_index_out), int'(bus.wt_read_index_in),
                         int'(bus.wt_read_index_y), int'(bus.wt_read_index_x)));
            check("bias_port", bus.wt_out_data_bias,
                  exp_bias(int'(bus.wt_read_index_out), int'(bus.wt_read_index_bias)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.act_write = 1'b0;
        bus.wt_weight_write = 1'b0;
        bus.wt_bias_write = 1'b0;
    endtask

    task automatic act_wr(input int e, input int y, input int x, input logic [63:0] d);
        bus.act_index_entry = 16'(e);
        bus.act_index_y = 16'(y);
        bus.act_index_x = 16'(x);
        bus.act_in_data = d;
        bus.act_write = 1'b1;
        tick();
        idle();
    endtask

    task automatic wt_wr(input logic w, input logic b, input int o, input int i,
                         input int ky, input int kx, input logic [63:0] d);
        bus.wt_index_out = 16'(o);
        bus.wt_index_in = 16'(i);
        bus.wt_index_k_y = 16'(ky);
        bus.wt_index_k_x = 16'(kx);
        bus.wt_in_data = d;
        bus.wt_weight_write = w;
        bus.wt_bias_write = b;
        tick();
        idle();
    endtask

    task automatic act_rd(input int e, input int y, input int x);
        bus.act_read_index_entry = 16'(e);
        bus.act_read_index_y = 16'(y);
        bus.act_read_index_x = 16'(x);
    endtask

    task automatic wt_rd(input int o, input int i, input int y, input int x, input int b);
        bus.wt_read_index_out = 16'(o);
        bus.wt_read_index_in = 16'(i);
        bus.wt_read_index_y = 16'(y);
        bus.wt_read_index_x = 16'(x);
        bus.wt_read_index_bias = 16'(b);
    endtask

    initial begin
        model_clear();
        idle();
        bus.act_in_data = '0;
        bus.wt_in_data = '0;
        bus.act_index_entry = '0; bus.act_index_y = '0; bus.act_index_x = '0;
        bus.wt_index_out = '0; bus.wt_index_in = '0; bus.wt_index_k_y = '0; bus.wt_index_k_x = '0;
        act_rd(0, 0, 0);
        wt_rd(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Post-reset reads
        #1 check("rst_act_x0", bus.act_out_data, 64'h0);
        check("rst_wt_0000", bus.wt_out_data_weight, 64'h0);
        check("rst_bias_0", bus.wt_out_data_bias, 64'h0);
        act_rd(0, 0, D);
        #1 check("rst_act_oor", bus.act_out_data, 64'h0);

        // Activation 1-D writes, readable in the same cycle the index is applied
        act_wr(0, 0, 2, F1_5);
        act_wr(0, 0, 3, F2_0);
        act_wr(1, 3, 1, 64'hC000000000000000);
        act_rd(0, 0, 2);
        #1 check("act_x2", bus.act_out_data, F1_5);
        act_rd(0, 0, 3);
        #1 check("act_x3", bus.act_out_data, F2_0);
        tick();

        // Fully connected weight/bias layout
        wt_wr(1'b1, 1'b0, 0, 0, 1, 3, F0_25);
        wt_wr(1'b0, 1'b1, 0, 0, 1, 0, FM1_0);
        wt_rd(0, 0, 1, 3, 1);
        #1 check("wt_y1x3", bus.wt_out_data_weight, F0_25);
        check("bias_1", bus.wt_out_data_bias, FM1_0);
        wt_rd(0, 0, 3, 1, 1);
        #1 check("wt_y3x1", bus.wt_out_data_weight, 64'h0);
        tick();

        // Shared data to weight and bias in one cycle
        wt_wr(1'b1, 1'b1, 0, 0, 2, 0, F3_0);
        wt_rd(0, 0, 2, 0, 2);
        #1 check("wt_y2x0_dual", bus.wt_out_data_weight, F3_0);
        check("bias_2_dual", bus.wt_out_data_bias, F3_0);
        tick();

        // Multi-channel addressing
        wt_wr(1'b1, 1'b0, 1, 1, 0, 2, 64'h1122334455667788);
        wt_wr(1'b0, 1'b1, 1, 0, 3, 0, 64'hDEADBEEFCAFEF00D);

        // Out-of-range writes; each would alias onto a real word if unchecked
        act_wr(0, 0, D, F7_0);
        act_wr(E, 0, 0, F7_0);
        act_wr(0, D, 0, F7_0);
        wt_wr(1'b1, 1'b0, 0, NI, 0, 0, F7_0);
        wt_wr(1'b1, 1'b0, 0, 0, 0, D, F7_0);
        wt_wr(1'b1, 1'b1, NO, 0, 0, 0, F7_0);
        wt_wr(1'b0, 1'b1, 0, 0, D, 0, F7_0);
        act_rd(0, 1, 0);
        #1 check("act_alias_0_1_0", bus.act_out_data, 64'h0);
        wt_rd(1, 0, 0, 0, 0);
        #1 check("wt_alias_1000", bus.wt_out_data_weight, 64'h0);
        check("bias_alias_1_0", bus.wt_out_data_bias, 64'h0);
        tick();

        // Full sweeps including one step past every extent
        for (int e = 0; e <= E; e++) for (int y = 0; y <= D; y++) for (int x = 0; x <= D; x++) begin
            act_rd(e, y, x);
            tick();
        end
        for (int o = 0; o <= NO; o++) for (int i = 0; i <= NI; i++)
            for (int y = 0; y <= D; y++) for (int x = 0; x <= D; x++) begin
                wt_rd(o, i, y, x, y);
                tick();
            end
        act_rd(16'hFFFF, 0, 0);
        wt_rd(0, 0, 16'hFFFF, 0, 16'hFFFF);
        tick();

        // Read-during-write: old value before the edge, new value after
        act_rd(0, 0, 2);
        bus.act_index_entry = 16'd0;
        bus.act_index_y = 16'd0;
        bus.act_index_x = 16'd2;
        bus.act_in_data = F5_0;
        bus.act_write = 1'b1;
        #1 check("rdw_before", bus.act_out_data, F1_5);
        tick();
        idle();
        check("rdw_after", bus.act_out_data, F5_0);
        tick();

        // Asynchronous reset between edges clears outputs immediately
        act_rd(0, 0, 3);
        wt_rd(0, 0, 1, 3, 1);
        #1 check("pre_rst_act", bus.act_out_data, F2_0);
        rst_n = 1'b0;
        #1 check("mid_rst_act", bus.act_out_data, 64'h0);
        check("mid_rst_wt", bus.wt_out_data_weight, 64'h0);
        check("mid_rst_bias", bus.wt_out_data_bias, 64'h0);

        // Writes while in reset are dropped
        act_wr(0, 0, 3, F7_0);
        wt_wr(1'b1, 1'b1, 0, 0, 1, 3, F7_0);
        tick();
        rst_n = 1'b1;
        #1 check("rst_wr_act", bus.act_out_data, 64'h0);
        check("rst_wr_wt", bus.wt_out_data_weight, 64'h0);
        check("rst_wr_bias", bus.wt_out_data_bias, 64'h0);

        // First edge after release accepts a write
        act_wr(0, 0, 3, F3_0);
        check("post_rst_wr", bus.act_out_data, F3_0);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
